// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - N-to-1 AXI read arbiter with ID widening, R routing and outstanding caps
module axi_read_arbiter #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int IW      = 4,
  parameter int DW      = 64,
  parameter int MAX_OUT = 4,
  localparam int IXW    = $clog2(N),
  localparam int CW     = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  // upstream AR channels (packed per master)
  input  logic [N-1:0]        m_ar_valid,
  output logic [N-1:0]        m_ar_ready,
  input  logic [N*IW-1:0]     m_ar_id,
  input  logic [N*AW-1:0]     m_ar_addr,
  input  logic [N*8-1:0]      m_ar_len,
  input  logic [N*3-1:0]      m_ar_size,
  input  logic [N*2-1:0]      m_ar_burst,
  // upstream R channels (shared payload)
  output logic [N-1:0]        m_r_valid,
  input  logic [N-1:0]        m_r_ready,
  output logic [IW-1:0]       m_r_id,
  output logic [DW-1:0]       m_r_data,
  output logic [1:0]          m_r_resp,
  output logic                m_r_last,
  // downstream AR channel
  output logic                s_ar_valid,
  input  logic                s_ar_ready,
  output logic [IW+IXW-1:0]   s_ar_id,
  output logic [AW-1:0]       s_ar_addr,
  output logic [7:0]          s_ar_len,
  output logic [2:0]          s_ar_size,
  output logic [1:0]          s_ar_burst,
  // downstream R channel
  input  logic                s_r_valid,
  output logic                s_r_ready,
  input  logic [IW+IXW-1:0]   s_r_id,
  input  logic [DW-1:0]       s_r_data,
  input  logic [1:0]          s_r_resp,
  input  logic                s_r_last
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  state_t            state_q, state_d;
  logic [IXW-1:0]    ptr_q;
  logic [CW-1:0]     cnt_q [N];

  logic [N-1:0]      elig;
  logic              win_found;
  logic [IXW-1:0]    win_idx;
  logic              grant;

  logic [IW-1:0]     sel_id;
  logic [AW-1:0]     sel_addr;
  logic [7:0]        sel_len;
  logic [2:0]        sel_size;
  logic [1:0]        sel_burst;

  logic [IW+IXW-1:0] ar_id_q;
  logic [AW-1:0]     ar_addr_q;
  logic [7:0]        ar_len_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;

  logic [IXW-1:0]    r_idx;
  logic              r_idx_ok;
  logic              r_done;
  logic [N-1:0]      inc;
  logic [N-1:0]      dec;

  // Eligibility: requesting and below the outstanding cap
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = m_ar_valid[i] && (cnt_q[i] < MAX_C);
    end
  end

  // Round-robin search starting at ptr_q, wrapping modulo N
  always_comb begin
    logic [IXW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      cand = IXW'((int'(ptr_q) + off) % N);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Payload mux for the current round-robin winner
  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IXW'(i)) begin
        sel_id    = m_ar_id[i*IW +: IW];
        sel_addr  = m_ar_addr[i*AW +: AW];
        sel_len   = m_ar_len[i*8 +: 8];
        sel_size  = m_ar_size[i*3 +: 3];
        sel_burst = m_ar_burst[i*2 +: 2];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one grant, then hold until the downstream accepts
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (s_ar_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grants only from IDLE, never while reset is asserted
  always_comb begin
    grant      = (state_q == IDLE) && win_found && !rst;
    s_ar_valid = (state_q == BUSY);
    for (int i = 0; i < N; i++) begin
      m_ar_ready[i] = grant && (win_idx == IXW'(i));
    end
  end

  // Registered AR payload and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else if (grant) begin
      ptr_q      <= (win_idx == IXW'(N - 1)) ? '0 : win_idx + IXW'(1);
      ar_id_q    <= {win_idx, sel_id};
      ar_addr_q  <= sel_addr;
      ar_len_q   <= sel_len;
      ar_size_q  <= sel_size;
      ar_burst_q <= sel_burst;
    end
  end

  assign s_ar_id    = ar_id_q;
  assign s_ar_addr  = ar_addr_q;
  assign s_ar_len   = ar_len_q;
  assign s_ar_size  = ar_size_q;
  assign s_ar_burst = ar_burst_q;

  // R routing by the index bits; unknown indices are sunk and dropped
  always_comb begin
    r_idx     = s_r_id[IW+IXW-1:IW];
    r_idx_ok  = 1'b0;
    s_r_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_r_valid[i] = 1'b0;
      if (r_idx == IXW'(i)) begin
        r_idx_ok     = 1'b1;
        s_r_ready    = m_r_ready[i];
        m_r_valid[i] = s_r_valid;
      end
    end
  end

  assign m_r_id   = s_r_id[IW-1:0];
  assign m_r_data = s_r_data;
  assign m_r_resp = s_r_resp;
  assign m_r_last = s_r_last;

  // Per-master increment on grant, decrement on the last beat of a burst
  always_comb begin
    r_done = s_r_valid && s_r_ready && s_r_last && r_idx_ok;
    for (int i = 0; i < N; i++) begin
      inc[i] = grant && (win_idx == IXW'(i));
      dec[i] = r_done && (r_idx == IXW'(i));
    end
  end

  // Outstanding counters; simultaneous inc/dec cancel, no wrap below zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        case ({inc[i], dec[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
          2'b01:   if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CW'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Flag a last beat returning for a master with nothing outstanding
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        assert (!(dec[i] && !inc[i] && (cnt_q[i] == '0)));
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - directed and randomized bench for axi_read_arbiter
module tb_axi_read_arbiter;

  localparam int N       = 2;
  localparam int AW      = 32;
  localparam int IW      = 4;
  localparam int DW      = 64;
  localparam int MAX_OUT = 4;
  localparam int IXW     = 1;
  localparam int SW      = IW + IXW;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_ar_valid;
  logic [N-1:0]    m_ar_ready;
  logic [N*IW-1:0] m_ar_id;
  logic [N*AW-1:0] m_ar_addr;
  logic [N*8-1:0]  m_ar_len;
  logic [N*3-1:0]  m_ar_size;
  logic [N*2-1:0]  m_ar_burst;
  logic [N-1:0]    m_r_valid;
  logic [N-1:0]    m_r_ready;
  logic [IW-1:0]   m_r_id;
  logic [DW-1:0]   m_r_data;
  logic [1:0]      m_r_resp;
  logic            m_r_last;
  logic            s_ar_valid;
  logic            s_ar_ready;
  logic [SW-1:0]   s_ar_id;
  logic [AW-1:0]   s_ar_addr;
  logic [7:0]      s_ar_len;
  logic [2:0]      s_ar_size;
  logic [1:0]      s_ar_burst;
  logic            s_r_valid;
  logic            s_r_ready;
  logic [SW-1:0]   s_r_id;
  logic [DW-1:0]   s_r_data;
  logic [1:0]      s_r_resp;
  logic            s_r_last;

  axi_read_arbiter #(
    .N(N), .AW(AW), .IW(IW), .DW(DW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding bursts per master, rotation pointer, pending AR
  int            mcnt [N];
  int            mptr;
  bit            mbusy;
  logic [SW-1:0] mid;
  logic [AW-1:0] maddr;
  logic [7:0]    mlen;
  logic [2:0]    msize;
  logic [1:0]    mburst;
  logic [N-1:0]  obs_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mptr = 0; mbusy = 0;
    mid = '0; maddr = '0; mlen = '0; msize = '0; mburst = '0;
  endtask

  // One clock: compare DUT against model before the edge, advance model at the edge
  task automatic step();
    int w = -1;
    int k;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic exp_sr;
    bit rdone;
    logic [SW-1:0] c_id;
    logic [AW-1:0] c_addr;
    logic [7:0] c_len;
    logic [2:0] c_size;
    logic [1:0] c_burst;
    #1;
    if (!mbusy && !rst) begin
      for (int off = 0; off < N; off++) begin
        int c = (mptr + off) % N;
        if (w < 0 && m_ar_valid[c] && mcnt[c] < MAX_OUT) w = c;
      end
    end
    exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
    k = int'(s_r_id >> IW);
    exp_rv = (s_r_valid && k < N) ? (N'(1) << k) : '0;
    exp_sr = (k < N) ? m_r_ready[k[IXW-1:0]] : 1'b1;
    obs_rdy = m_ar_ready;
    check("m_ar_ready", m_ar_ready, exp_rdy);
    check("s_ar_valid", s_ar_valid, mbusy);
    check("s_ar_id", s_ar_id, mid);
    check("s_ar_addr", s_ar_addr, maddr);
    check("s_ar_len", s_ar_len, mlen);
    check("s_ar_size", s_ar_size, msize);
    check("s_ar_burst", s_ar_burst, mburst);
    check("m_r_valid", m_r_valid, exp_rv);
    check("s_r_ready", s_r_ready, exp_sr);
    check("m_r_id", m_r_id, s_r_id[IW-1:0]);
    check("m_r_data", m_r_data, s_r_data);
    check("m_r_resp_last", {m_r_resp, m_r_last}, {s_r_resp, s_r_last});
    rdone = s_r_valid && exp_sr && s_r_last && (k < N);
    if (w >= 0) begin
      c_id = {IXW'(w), m_ar_id[w*IW +: IW]};
      c_addr = m_ar_addr[w*AW +: AW];
      c_len = m_ar_len[w*8 +: 8];
      c_size = m_ar_size[w*3 +: 3];
      c_burst = m_ar_burst[w*2 +: 2];
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (w >= 0) begin
        mbusy = 1; mid = c_id; maddr = c_addr; mlen = c_len; msize = c_size; mburst = c_burst;
        mcnt[w]++;
        mptr = (w + 1) % N;
      end else if (mbusy && s_ar_ready) begin
        mbusy = 0;
      end
      if (rdone) mcnt[k] = (mcnt[k] > 0) ? mcnt[k] - 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input bit v, input logic [IW-1:0] id,
                       input logic [AW-1:0] addr, input logic [7:0] len);
    m_ar_valid[i] = v;
    m_ar_id[i*IW +: IW] = id;
    m_ar_addr[i*AW +: AW] = addr;
    m_ar_len[i*8 +: 8] = len;
    m_ar_size[i*3 +: 3] = 3'd3;
    m_ar_burst[i*2 +: 2] = 2'b01;
  endtask

  // Single last beat of a burst for master index k
  task automatic r_last(input int k);
    s_r_valid = 1'b1;
    s_r_id = {IXW'(k), IW'($urandom)};
    s_r_data = {$urandom, $urandom};
    s_r_resp = 2'($urandom);
    s_r_last = 1'b1;
    step();
    s_r_valid = 1'b0;
    s_r_last = 1'b0;
  endtask

  task automatic drain();
    m_ar_valid = '0;
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < 2 * MAX_OUT && mcnt[i] > 0; g++) r_last(i);
    end
    step();
  endtask

  initial begin
    int n;
    logic [N-1:0] pat [8];
    model_reset();
    rst = 1'b1;
    s_ar_ready = 1'b1; m_r_ready = '1;
    s_r_valid = 1'b1; s_r_id = '0; s_r_data = '0; s_r_resp = '0; s_r_last = 1'b0;
    set_m(0, 1, 4'h1, 32'h100, 8'd1);
    set_m(1, 1, 4'h2, 32'h200, 8'd2);
    @(negedge clk);

    // Reset held two cycles with all inputs active
    step(); check("rst_rdy_0", obs_rdy, 2'b00);
    step(); check("rst_rdy_1", obs_rdy, 2'b00);
    check("rst_sav", s_ar_valid, 1'b0);
    check("rst_addr", s_ar_addr, 32'h0);
    rst = 1'b0; s_r_valid = 1'b0; m_ar_valid = '0;
    step();

    // Single request from master 1
    set_m(1, 1, 4'h3, 32'h1000, 8'd7);
    step(); check("single_rdy", obs_rdy, 2'b10);
    m_ar_valid = '0;
    check("single_sav", s_ar_valid, 1'b1);
    check("single_id", s_ar_id, 5'h13);
    check("single_addr", s_ar_addr, 32'h1000);
    check("single_len", s_ar_len, 8'd7);
    step(); check("single_sav_drop", s_ar_valid, 1'b0);

    // Contention: alternate 0,1,0,1 with one grant every two cycles
    pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    set_m(0, 1, 4'h1, 32'h2000, 8'd0);
    set_m(1, 1, 4'h2, 32'h3000, 8'd3);
    for (int c = 0; c < 8; c++) begin
      step(); check($sformatf("contend_%0d", c), obs_rdy, pat[c]);
    end
    drain();

    // Outstanding cap on master 0
    n = 0;
    set_m(0, 1, 4'h4, 32'h4000, 8'd1);
    for (int c = 0; c < 8; c++) begin step(); n += int'(obs_rdy[0]); end
    check("limit_four", n, 4);
    set_m(1, 1, 4'h5, 32'h5000, 8'd2);
    step(); check("limit_m1_served", obs_rdy, 2'b10);
    m_ar_valid[1] = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      step(); check($sformatf("limit_block_%0d", c), obs_rdy, 2'b00);
    end
    r_last(0);
    step(); check("limit_regrant", obs_rdy, 2'b01);
    step();

    // Grant and last beat to master 0 in the same cycle at count 2
    m_ar_valid = '0;
    r_last(0); r_last(0);
    m_ar_valid[0] = 1'b1;
    s_r_valid = 1'b1; s_r_id = {1'b0, 4'h9}; s_r_last = 1'b1;
    step(); check("simul_grant", obs_rdy, 2'b01);
    s_r_valid = 1'b0; s_r_last = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin step(); n += int'(obs_rdy[0]); end
    check("simul_room_left", n, 2);
    drain();

    // R routing and back-pressure
    s_r_valid = 1'b1; s_r_id = 5'h15; s_r_last = 1'b0;
    s_r_data = 64'hDEAD_BEEF_0123_4567; s_r_resp = 2'b10;
    m_r_ready = 2'b01;
    #1;
    check("route_valid", m_r_valid, 2'b10);
    check("route_bp", s_r_ready, 1'b0);
    step();
    m_r_ready = 2'b11;
    #1;
    check("route_accept", s_r_ready, 1'b1);
    check("route_data", m_r_data, 64'hDEAD_BEEF_0123_4567);
    check("route_id", m_r_id, 4'h5);
    step();
    s_r_valid = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      int k;
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++)
        set_m(i, 1'($urandom), IW'($urandom), $urandom, 8'($urandom));
      s_ar_ready = 1'($urandom);
      m_r_ready = N'($urandom);
      s_r_valid = 1'($urandom);
      s_r_id = SW'($urandom);
      s_r_data = {$urandom, $urandom};
      s_r_resp = 2'($urandom);
      k = int'(s_r_id >> IW);
      s_r_last = 1'($urandom) && (mcnt[k] > 0);
      step();
    end
    rst = 1'b0; s_r_valid = 1'b0; s_r_last = 1'b0; s_ar_ready = 1'b1; m_r_ready = '1;
    drain();

    // Reset while a downstream AR is pending
    set_m(0, 1, 4'h7, 32'h7000, 8'd4);
    step(); step(); step();
    set_m(0, 1, 4'h7, 32'h7000, 8'd4);
    s_ar_ready = 1'b0;
    step();
    m_ar_valid = '0;
    step();
    check("midrst_pending", s_ar_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_sav", s_ar_valid, 1'b0);
    check("midrst_addr", s_ar_addr, 32'h0);
    s_ar_ready = 1'b1;
    set_m(0, 1, 4'h1, 32'h8000, 8'd0);
    set_m(1, 1, 4'h2, 32'h9000, 8'd0);
    step(); check("midrst_ptr", obs_rdy, 2'b01);
    m_ar_valid = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
